// File: rtl/pdp8_boot_pkg.sv
// Shared types and constants for the RIM bootstrap sequencer.
// Holds the FSM state encoding, the loader mode encodings and both loader images.
package pdp8_boot_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_PCLOAD,
    S_RELEASE,
    S_DONE
  } state_t;

  localparam logic MODE_LS = 1'b0;
  localparam logic MODE_HS = 1'b1;

  // Teletype (KSF/KRB) and high-speed reader (RSF/RRB) RIM loaders, word 0 at BASE_ADDR.
  localparam logic [11:0] LS_IMAGE [16] = '{
    12'o6032, 12'o6031, 12'o5357, 12'o6036, 12'o7106, 12'o7006, 12'o7510, 12'o5357,
    12'o7006, 12'o6031, 12'o5367, 12'o6034, 12'o7420, 12'o3776, 12'o3376, 12'o5356
  };

  localparam logic [11:0] HS_IMAGE [16] = '{
    12'o6014, 12'o6011, 12'o5357, 12'o6016, 12'o7106, 12'o7006, 12'o7510, 12'o5374,
    12'o7006, 12'o6011, 12'o5367, 12'o6016, 12'o7420, 12'o3776, 12'o3376, 12'o5357
  };

endpackage

// File: rtl/rim_image_rom.sv
// Combinational lookup of one RIM loader word.
// Indices 16 and up are the zeroed tail words.
module rim_image_rom
  import pdp8_boot_pkg::*;
(
  input  logic        mode,
  input  logic [4:0]  idx,
  output logic [11:0] word
);

  always_comb begin
    word = '0;
    if (!idx[4])
      word = (mode == MODE_HS) ? HS_IMAGE[idx[3:0]] : LS_IMAGE[idx[3:0]];
  end

endmodule

// File: rtl/rim_boot_sequencer.sv
// Bootstrap sequencer: halts the CPU, takes the RAM bus, writes a RIM loader,
// loads the PC with the loader start and releases the bus.
module rim_boot_sequencer
  import pdp8_boot_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR    = 12'o7756,
  parameter int          CLEAR_TAIL   = 1,
  parameter int          SETUP_CYCLES = 1,
  parameter int          WE_CYCLES    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode,
  output logic        halt_req,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [11:0] address,
  output logic [11:0] data,
  output logic        we,
  output logic        pc_load,
  output logic [11:0] pc_value,
  output logic        busy,
  output logic        done
);

  localparam int         NWORDS     = (CLEAR_TAIL != 0) ? 18 : 16;
  localparam logic [4:0] LAST_IDX   = 5'(NWORDS - 1);
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] WE_LAST    = 8'(WE_CYCLES - 1);

  state_t      state;
  logic [4:0]  idx;
  logic [7:0]  cnt;
  logic        mode_q;
  logic [4:0]  rom_idx;
  logic [11:0] rom_word;
  logic [11:0] next_addr;

  // Outputs are registered, so look up the word for the state being entered.
  always_comb begin
    rom_idx   = (state == S_HOLD) ? idx + 5'd1 : idx;
    next_addr = BASE_ADDR + {7'd0, rom_idx};
  end

  rim_image_rom u_rom (
    .mode (mode_q),
    .idx  (rom_idx),
    .word (rom_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      cnt      <= '0;
      mode_q   <= MODE_LS;
      halt_req <= 1'b0;
      bus_req  <= 1'b0;
      address  <= '0;
      data     <= '0;
      we       <= 1'b0;
      pc_load  <= 1'b0;
      pc_value <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      pc_load  <= 1'b0;
      done     <= 1'b0;
      pc_value <= BASE_ADDR;
      // Grant loss in any bus-owning write state drops the strobe and re-requests
      // with idx kept, so the interrupted word is rewritten from SETUP.
      if ((state == S_SETUP || state == S_STROBE || state == S_HOLD) && !bus_gnt) begin
        state   <= S_REQ;
        we      <= 1'b0;
        address <= '0;
        data    <= '0;
        cnt     <= '0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            mode_q   <= mode;
            idx      <= '0;
            state    <= S_REQ;
            halt_req <= 1'b1;
            bus_req  <= 1'b1;
            busy     <= 1'b1;
          end
          S_REQ: if (bus_gnt) begin
            state   <= S_SETUP;
            cnt     <= '0;
            address <= next_addr;
            data    <= rom_word;
          end
          S_SETUP: begin
            if (cnt == SETUP_LAST) begin
              state <= S_STROBE;
              cnt   <= '0;
              we    <= 1'b1;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          S_STROBE: begin
            if (cnt == WE_LAST) begin
              state <= S_HOLD;
              cnt   <= '0;
              we    <= 1'b0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          S_HOLD: begin
            if (idx == LAST_IDX) begin
              state   <= S_PCLOAD;
              pc_load <= 1'b1;
              address <= '0;
              data    <= '0;
            end else begin
              idx     <= idx + 5'd1;
              state   <= S_SETUP;
              cnt     <= '0;
              address <= next_addr;
              data    <= rom_word;
            end
          end
          S_PCLOAD: begin
            state    <= S_RELEASE;
            bus_req  <= 1'b0;
            halt_req <= 1'b0;
          end
          S_RELEASE: begin
            state <= S_DONE;
            done  <= 1'b1;
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rim_boot_sequencer.sv
// Directed bench for rim_boot_sequencer: default build (dut a) and a
// 16-word, 2-setup/3-strobe build at 0200 (dut b).
module tb_rim_boot_sequencer;

  typedef struct {
    logic [11:0] addr;
    logic [11:0] data;
    int          cyc;
    int          len;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, mode_a = 1'b0, gnt_a = 1'b1;
  logic        start_b = 1'b0, mode_b = 1'b0, gnt_b = 1'b1;
  logic        a_halt, a_breq, a_we, a_pcl, a_busy, a_done;
  logic [11:0] a_addr, a_data, a_pcv;
  logic        b_halt, b_breq, b_we, b_pcl, b_busy, b_done;
  logic [11:0] b_addr, b_data, b_pcv;

  rim_boot_sequencer u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a),
    .halt_req(a_halt), .bus_req(a_breq), .bus_gnt(gnt_a),
    .address(a_addr), .data(a_data), .we(a_we),
    .pc_load(a_pcl), .pc_value(a_pcv), .busy(a_busy), .done(a_done)
  );

  rim_boot_sequencer #(
    .BASE_ADDR(12'o0200), .CLEAR_TAIL(0), .SETUP_CYCLES(2), .WE_CYCLES(3)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b),
    .halt_req(b_halt), .bus_req(b_breq), .bus_gnt(gnt_b),
    .address(b_addr), .data(b_data), .we(b_we),
    .pc_load(b_pcl), .pc_value(b_pcv), .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (o%0o) expected %0d (o%0o)", nm, act, act, exp, exp);
    end
  endtask

  // Write monitor on the selected dut: one record per WE pulse.
  bit          sel = 1'b0;
  bit          mon_on = 1'b0;
  logic        prev_we = 1'b0;
  int          wcnt = 0;
  int          w_cyc [64];
  int          w_len [64];
  logic [11:0] w_addr [64];
  logic [11:0] w_data [64];
  int          pc_cyc = -1, done_cnt = 0, done_cyc = -1;
  logic [11:0] pc_val = '0;

  always @(negedge clk) if (mon_on) begin
    if ((sel ? b_we : a_we) && !prev_we && wcnt < 64) begin
      w_cyc[wcnt]  = cyc - t0;
      w_addr[wcnt] = sel ? b_addr : a_addr;
      w_data[wcnt] = sel ? b_data : a_data;
      w_len[wcnt]  = 0;
      wcnt++;
    end
    if ((sel ? b_we : a_we) && wcnt > 0) w_len[wcnt-1]++;
    prev_we = sel ? b_we : a_we;
    if (sel ? b_pcl : a_pcl) begin
      pc_cyc = cyc - t0;
      pc_val = sel ? b_pcv : a_pcv;
    end
    if (sel ? b_done : a_done) begin
      done_cnt++;
      done_cyc = cyc - t0;
    end
  end

  // Cycle 0 is the cycle in which start is high.
  task automatic start_run(input bit s, input bit m);
    @(posedge clk); #1;
    mon_on = 1'b0; wcnt = 0; prev_we = 1'b0;
    pc_cyc = -1; done_cnt = 0; done_cyc = -1; pc_val = '0;
    sel = s; mon_on = 1'b1;
    t0 = cyc;
    if (s) begin start_b = 1'b1; mode_b = m; end
    else   begin start_a = 1'b1; mode_a = m; end
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic go_cyc(input int n);
    while (cyc - t0 < n) begin @(posedge clk); #1; end
  endtask

  logic [11:0] ls_img [16];
  logic [11:0] hs_img [16];
  vec_t        vt [18];

  task automatic build(input bit hs, input logic [11:0] base, input int nw,
                       input int first, input int step, input int len);
    for (int k = 0; k < 18; k++) begin
      vt[k].addr = base + 12'(k);
      vt[k].data = (k >= 16) ? 12'o0000 : (hs ? hs_img[k] : ls_img[k]);
      vt[k].cyc  = first + step * k;
      vt[k].len  = (k < nw) ? len : 0;
    end
  endtask

  task automatic cmp_table(input string tag, input int nw);
    chk({tag, " writes"}, wcnt, nw);
    for (int k = 0; k < nw; k++) begin
      chk($sformatf("%s w%0d addr", tag, k), int'(w_addr[k]), int'(vt[k].addr));
      chk($sformatf("%s w%0d data", tag, k), int'(w_data[k]), int'(vt[k].data));
      chk($sformatf("%s w%0d cyc", tag, k), w_cyc[k], vt[k].cyc);
      chk($sformatf("%s w%0d len", tag, k), w_len[k], vt[k].len);
    end
  endtask

  initial begin
    ls_img = '{12'o6032, 12'o6031, 12'o5357, 12'o6036, 12'o7106, 12'o7006, 12'o7510, 12'o5357,
               12'o7006, 12'o6031, 12'o5367, 12'o6034, 12'o7420, 12'o3776, 12'o3376, 12'o5356};
    hs_img = '{12'o6014, 12'o6011, 12'o5357, 12'o6016, 12'o7106, 12'o7006, 12'o7510, 12'o5374,
               12'o7006, 12'o6011, 12'o5367, 12'o6016, 12'o7420, 12'o3776, 12'o3376, 12'o5357};

    // Reset state
    #2;
    chk("rst busy", int'(a_busy), 0);
    chk("rst we", int'(a_we), 0);
    chk("rst bus_req", int'(a_breq), 0);
    chk("rst halt_req", int'(a_halt), 0);
    chk("rst address", int'(a_addr), 0);
    chk("rst done", int'(a_done), 0);
    chk("rst pc_load", int'(a_pcl), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Defaults, low-speed image, grant tied high
    build(1'b0, 12'o7756, 18, 3, 3, 1);
    start_run(1'b0, 1'b0);
    go_cyc(1);
    chk("ls bus_req c1", int'(a_breq), 1);
    chk("ls halt_req c1", int'(a_halt), 1);
    go_cyc(58);
    chk("ls busy c58", int'(a_busy), 1);
    go_cyc(59);
    chk("ls busy c59", int'(a_busy), 0);
    chk("ls address c59", int'(a_addr), 0);
    chk("ls bus_req c59", int'(a_breq), 0);
    go_cyc(66);
    cmp_table("ls", 18);
    chk("ls pc_load cyc", pc_cyc, 56);
    chk("ls pc_value", int'(pc_val), int'(12'o7756));
    chk("ls done cyc", done_cyc, 58);
    chk("ls done count", done_cnt, 1);

    // High-speed image; mode toggle and extra starts while busy
    build(1'b1, 12'o7756, 18, 3, 3, 1);
    start_run(1'b0, 1'b1);
    go_cyc(2);  mode_a = 1'b0; start_a = 1'b1;
    go_cyc(3);  start_a = 1'b0;
    go_cyc(20); start_a = 1'b1;
    go_cyc(21); start_a = 1'b0;
    go_cyc(66);
    cmp_table("hs", 18);
    chk("hs 7765", int'(w_data[7]), int'(12'o5374));
    chk("hs 7775", int'(w_data[15]), int'(12'o5357));
    chk("hs done count", done_cnt, 1);
    chk("hs done cyc", done_cyc, 58);

    // Delayed grant, then grant loss during the strobe of word 5
    gnt_a = 1'b0;
    start_run(1'b0, 1'b0);
    go_cyc(1);
    chk("gnt bus_req", int'(a_breq), 1);
    go_cyc(11);
    chk("gnt no we before grant", wcnt, 0);
    gnt_a = 1'b1;
    go_cyc(28);
    chk("gnt w5 strobe we", int'(a_we), 1);
    chk("gnt w5 strobe addr", int'(a_addr), int'(12'o7763));
    gnt_a = 1'b0;
    go_cyc(29);
    chk("gnt lost we", int'(a_we), 0);
    chk("gnt lost bus_req", int'(a_breq), 1);
    chk("gnt lost halt_req", int'(a_halt), 1);
    go_cyc(31);
    gnt_a = 1'b1;
    go_cyc(80);
    chk("gnt writes", wcnt, 19);
    chk("gnt first we cyc", w_cyc[0], 13);
    chk("gnt w5 addr", int'(w_addr[5]), int'(12'o7763));
    chk("gnt rewrite addr", int'(w_addr[6]), int'(12'o7763));
    chk("gnt rewrite data", int'(w_data[6]), int'(12'o7006));
    chk("gnt rewrite cyc", w_cyc[6], 33);
    chk("gnt w6 addr", int'(w_addr[7]), int'(12'o7764));
    chk("gnt w6 data", int'(w_data[7]), int'(12'o7510));
    chk("gnt done cyc", done_cyc, 73);
    chk("gnt done count", done_cnt, 1);

    // Asynchronous reset in the middle of the strobe of word 8
    start_run(1'b0, 1'b0);
    go_cyc(27);
    chk("arst pre we", int'(a_we), 1);
    chk("arst pre addr", int'(a_addr), int'(12'o7766));
    #2 rst_n = 1'b0;
    #1;
    chk("arst we", int'(a_we), 0);
    chk("arst bus_req", int'(a_breq), 0);
    chk("arst halt_req", int'(a_halt), 0);
    chk("arst busy", int'(a_busy), 0);
    chk("arst address", int'(a_addr), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    build(1'b0, 12'o7756, 18, 3, 3, 1);
    start_run(1'b0, 1'b0);
    go_cyc(66);
    cmp_table("rerun", 18);
    chk("rerun done cyc", done_cyc, 58);

    // Alternate build: 16 words at 0200, 2 setup + 3 strobe cycles per word
    build(1'b0, 12'o0200, 16, 4, 6, 3);
    start_run(1'b1, 1'b0);
    go_cyc(108);
    cmp_table("alt", 16);
    chk("alt pc_load cyc", pc_cyc, 98);
    chk("alt pc_value", int'(pc_val), int'(12'o0200));
    chk("alt done cyc", done_cyc, 100);
    chk("alt done count", done_cnt, 1);
    chk("alt busy end", int'(b_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
